// File: rtl/updown_counter_gen_if.sv
// Control/status bundle for updown_counter_gen: count controls and direction button in, count state out.
interface updown_counter_gen_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sclr;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             choose;
    logic [WIDTH-1:0] q;
    logic             dir;
    logic             tc;

    modport master (
        output sclr, enable, load, data, choose,
        input  q, dir, tc
    );

    modport slave (
        input  sclr, enable, load, data, choose,
        output q, dir, tc
    );
endinterface

// File: rtl/updown_counter_gen.sv
// Loadable up/down counter with a terminal value, wrap/saturate ends and a synchronised direction button.
// Define UPDOWN_COUNTER_DEBOUNCE_EN to insert a DB_CYCLES stability filter on the button.
module updown_counter_gen #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter bit               SATURATE  = 1'b0,
    parameter int unsigned      DB_CYCLES = 16
) (
    input  logic                clk,
    input  logic                clr_n,
    updown_counter_gen_if.slave bus
);

    if (WIDTH < 2 || WIDTH > 32 || DB_CYCLES < 1) begin : g_bad_params
        $error("updown_counter_gen: parameter out of range");
    end

    logic             sync1;
    logic             sync2;
    logic             lvl;
    logic             lvl_q;
    logic             rise_c;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic             dir_r;
    logic             dir_next;
    logic             tc_r;
    logic             tc_next;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.choose;
            sync2 <= sync1;
        end
    end

`ifdef UPDOWN_COUNTER_DEBOUNCE_EN
    localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [DB_W-1:0] db_cnt;
    logic            filt;

    // Filtered level follows sync2 only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            db_cnt <= '0;
            filt   <= 1'b0;
        end else if (sync2 == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            filt   <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    assign lvl = filt;
`else
    assign lvl = sync2;
`endif

    assign rise_c = lvl & ~lvl_q;

    // Next count, direction and terminal flag; sclr swallows a coincident button edge
    always_comb begin
        q_next   = q_r;
        dir_next = dir_r;
        tc_next  = 1'b0;
        if (bus.sclr) begin
            q_next   = '0;
            dir_next = 1'b0;
        end else begin
            dir_next = dir_r ^ rise_c;
            if (bus.load) begin
                q_next = (bus.data > MAX_VAL) ? MAX_VAL : bus.data;
            end else if (bus.enable) begin
                if (!dir_r) begin
                    if (q_r > MAX_VAL) begin
                        q_next = '0;
                    end else if (q_r == MAX_VAL) begin
                        q_next  = SATURATE ? MAX_VAL : '0;
                        tc_next = 1'b1;
                    end else begin
                        q_next = q_r + WIDTH'(1);
                    end
                end else begin
                    if (q_r > MAX_VAL) begin
                        q_next = MAX_VAL;
                    end else if (q_r == '0) begin
                        q_next  = SATURATE ? '0 : MAX_VAL;
                        tc_next = 1'b1;
                    end else begin
                        q_next = q_r - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_r   <= '0;
            dir_r <= 1'b0;
            tc_r  <= 1'b0;
            lvl_q <= 1'b0;
        end else begin
            q_r   <= q_next;
            dir_r <= dir_next;
            tc_r  <= tc_next;
            lvl_q <= lvl;
        end
    end

    assign bus.q   = q_r;
    assign bus.dir = dir_r;
    assign bus.tc  = tc_r;

endmodule

// File: tb/tb_updown_counter_gen.sv
// Directed bench for updown_counter_gen: a wrapping and a saturating instance, both WIDTH=8, MAX_VAL=9.
module tb_updown_counter_gen;

    localparam int unsigned W = 8;
`ifdef UPDOWN_COUNTER_DEBOUNCE_EN
    localparam int unsigned TOG = 3 + 16;
`else
    localparam int unsigned TOG = 3;
`endif

    logic clk = 1'b0;
    logic clr_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    updown_counter_gen_if #(.WIDTH(W)) ia ();
    updown_counter_gen_if #(.WIDTH(W)) ib ();

    updown_counter_gen #(.WIDTH(W), .MAX_VAL(8'd9), .SATURATE(1'b0), .DB_CYCLES(16)) dut_wrap (
        .clk(clk), .clr_n(clr_n), .bus(ia)
    );

    updown_counter_gen #(.WIDTH(W), .MAX_VAL(8'd9), .SATURATE(1'b1), .DB_CYCLES(16)) dut_sat (
        .clk(clk), .clr_n(clr_n), .bus(ib)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_q(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        clr_n     = 1'b0;
        ia.sclr   = 1'b0; ia.enable = 1'b0; ia.load = 1'b0; ia.data = 8'd0; ia.choose = 1'b0;
        ib.sclr   = 1'b0; ib.enable = 1'b0; ib.load = 1'b0; ib.data = 8'd0; ib.choose = 1'b0;

        #2;
        check_q("rst_q", ia.q, 8'd0);
        check_b("rst_dir", ia.dir, 1'b0);
        check_b("rst_tc", ia.tc, 1'b0);
        check_q("rst_q_sat", ib.q, 8'd0);

        #10;
        clr_n     = 1'b1;
        ia.enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_q("wrap_q", ia.q, (i <= 9) ? 8'(i) : 8'(i - 10));
            check_b("wrap_tc", ia.tc, i == 10);
        end

        ia.enable = 1'b0;
        tick();
        check_q("hold_q", ia.q, 8'd2);
        check_b("hold_tc", ia.tc, 1'b0);

        ia.load = 1'b1; ia.data = 8'd200;
        tick();
        check_q("load_clamp_q", ia.q, 8'd9);
        check_b("load_clamp_tc", ia.tc, 1'b0);
        ia.load = 1'b0; ia.enable = 1'b1;
        tick();
        check_q("after_clamp_q", ia.q, 8'd0);
        check_b("after_clamp_tc", ia.tc, 1'b1);

`ifndef UPDOWN_COUNTER_DEBOUNCE_EN
        begin : press_count
            logic [7:0] exp_q   [10] = '{8'd4, 8'd5, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd9};
            logic       exp_dir [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            logic       exp_tc  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            ia.load = 1'b1; ia.data = 8'd3;
            tick();
            check_q("load3_q", ia.q, 8'd3);
            ia.load   = 1'b0;
            ia.choose = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                check_q("press_q", ia.q, exp_q[i]);
                check_b("press_dir", ia.dir, exp_dir[i]);
                check_b("press_tc", ia.tc, exp_tc[i]);
                if (i == 4) ia.choose = 1'b0;
            end
        end
`else
        ia.enable = 1'b0;
        ia.choose = 1'b1;
        repeat (3) tick();
        ia.choose = 1'b0;
        repeat (TOG + 2) tick();
        check_b("glitch_dir", ia.dir, 1'b0);
        ia.choose = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_b("db_press_dir", ia.dir, i >= 19);
        end
        ia.choose = 1'b0;
        repeat (TOG) tick();
        check_b("db_release_dir", ia.dir, 1'b1);
`endif

        // sclr and load coincide with the detected button edge
        ia.enable = 1'b1;
        ia.choose = 1'b1;
        repeat (TOG - 1) tick();
        ia.sclr = 1'b1; ia.load = 1'b1; ia.data = 8'd5;
        tick();
        check_q("sclr_q", ia.q, 8'd0);
        check_b("sclr_dir", ia.dir, 1'b0);
        check_b("sclr_tc", ia.tc, 1'b0);
        ia.sclr = 1'b0; ia.load = 1'b0; ia.enable = 1'b0;
        tick();
        check_b("sclr_no_late_toggle", ia.dir, 1'b0);
        check_q("sclr_hold_q", ia.q, 8'd0);
        ia.choose = 1'b0;
        repeat (TOG) tick();

        ia.choose = 1'b1;
        repeat (TOG - 1) tick();
        check_b("dis_toggle_before", ia.dir, 1'b0);
        tick();
        check_b("dis_toggle_dir", ia.dir, 1'b1);
        check_q("dis_toggle_q", ia.q, 8'd0);
        ia.choose = 1'b0;
        repeat (TOG) tick();
        check_b("held_once_dir", ia.dir, 1'b1);

        ia.enable = 1'b1;
        tick();
        check_q("down_wrap_q", ia.q, 8'd9);
        check_b("down_wrap_tc", ia.tc, 1'b1);
        #2;
        clr_n = 1'b0;
        #1;
        check_q("async_rst_q", ia.q, 8'd0);
        check_b("async_rst_dir", ia.dir, 1'b0);
        check_b("async_rst_tc", ia.tc, 1'b0);
        #2;
        clr_n = 1'b1;
        tick();
        check_q("resume_q", ia.q, 8'd1);
        check_b("resume_dir", ia.dir, 1'b0);
        ia.enable = 1'b0;

        ib.load = 1'b1; ib.data = 8'd7;
        tick();
        check_q("sat_load_q", ib.q, 8'd7);
        ib.load = 1'b0; ib.enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_q("sat_up_q", ib.q, (i <= 2) ? 8'(7 + i) : 8'd9);
            check_b("sat_up_tc", ib.tc, i >= 3);
        end
        ib.enable = 1'b0;
        tick();
        check_q("sat_hold_q", ib.q, 8'd9);
        check_b("sat_hold_tc", ib.tc, 1'b0);

        ib.choose = 1'b1;
        repeat (TOG) tick();
        check_b("sat_dir", ib.dir, 1'b1);
        ib.choose = 1'b0;
        ib.load = 1'b1; ib.data = 8'd1;
        tick();
        check_q("sat_load1_q", ib.q, 8'd1);
        ib.load = 1'b0; ib.enable = 1'b1;
        tick();
        check_q("sat_dn_q0", ib.q, 8'd0);
        check_b("sat_dn_tc0", ib.tc, 1'b0);
        tick();
        check_q("sat_dn_q1", ib.q, 8'd0);
        check_b("sat_dn_tc1", ib.tc, 1'b1);
        tick();
        check_q("sat_dn_q2", ib.q, 8'd0);
        check_b("sat_dn_tc2", ib.tc, 1'b1);
        ib.enable = 1'b0;
        ib.load = 1'b1; ib.data = 8'd255;
        tick();
        check_q("sat_clamp_q", ib.q, 8'd9);
        ib.load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
